// File: rtl/pos_edge_detector.sv
// pos_edge_detector: registered rising/falling edge pulses for a level input,
// with an optional input synchronizer and a saturating rising-edge counter.
module pos_edge_detector #(
  parameter int SYNC_STAGES = 0,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             signal_in,
  output logic             pos_edge,
  output logic             neg_edge,
  output logic [CNT_W-1:0] rise_count
);

  logic s;
  logic prev;
  logic rise;
  logic fall;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = signal_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      // Shift chain bringing signal_in into the clk domain; s is the last stage.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= signal_in;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign rise = s & ~prev;
  assign fall = ~s & prev;

  // Previous-sample register and registered edge pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev     <= 1'b0;
      pos_edge <= 1'b0;
      neg_edge <= 1'b0;
    end else begin
      prev     <= s;
      pos_edge <= rise;
      neg_edge <= fall;
    end
  end

  // Rising-edge counter; holds at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_count <= '0;
    end else if (rise && (rise_count != {CNT_W{1'b1}})) begin
      rise_count <= rise_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pos_edge_detector.sv
// Directed bench: two detector instances (no synchronizer / 8-bit count, and
// 2-stage synchronizer / 2-bit count) share one input and reset.
module tb_pos_edge_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic       signal_in;
  logic       pos_a, neg_a;
  logic [7:0] cnt_a;
  logic       pos_b, neg_b;
  logic [1:0] cnt_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pos_edge_detector #(.SYNC_STAGES(0), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .signal_in(signal_in),
    .pos_edge(pos_a), .neg_edge(neg_a), .rise_count(cnt_a)
  );

  pos_edge_detector #(.SYNC_STAGES(2), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .signal_in(signal_in),
    .pos_edge(pos_b), .neg_edge(neg_b), .rise_count(cnt_b)
  );

  typedef struct {
    logic       rst;
    logic       sin;
    logic       a_pos;
    logic       a_neg;
    logic [7:0] a_cnt;
    logic       b_pos;
    logic       b_neg;
    logic [1:0] b_cnt;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic ap, input logic an, input logic [7:0] ac,
                           input logic bp, input logic bn, input logic [1:0] bc);
    check("a_pos_edge", idx, 32'(pos_a), 32'(ap));
    check("a_neg_edge", idx, 32'(neg_a), 32'(an));
    check("a_rise_count", idx, 32'(cnt_a), 32'(ac));
    check("b_pos_edge", idx, 32'(pos_b), 32'(bp));
    check("b_neg_edge", idx, 32'(neg_b), 32'(bn));
    check("b_rise_count", idx, 32'(cnt_b), 32'(bc));
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    //          rst   sin   a:pos neg cnt   b:pos neg cnt
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 2'd0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 2'd0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 2'd1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 2'd1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 2'd1};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 1'b0, 1'b1, 2'd1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0, 2'd1};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd3, 1'b1, 1'b0, 2'd2};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 1'b0, 1'b1, 2'd2};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd4, 1'b1, 1'b0, 2'd3};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b1, 2'd3};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd5, 1'b1, 1'b0, 2'd3};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd5, 1'b0, 1'b1, 2'd3};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 1'b1, 1'b0, 2'd3};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 1'b0, 1'b1, 2'd3};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 1'b0, 0, 2'd3};

    rst       = 1'b1;
    signal_in = 1'b0;

    // Table: drive away from the edge, check 1 time unit after the rising edge.
    for (int i = 0; i < 20; i++) begin
      rst       = vecs[i].rst;
      signal_in = vecs[i].sin;
      @(posedge clk);
      #1;
      check_all(i, vecs[i].a_pos, vecs[i].a_neg, vecs[i].a_cnt,
                vecs[i].b_pos, vecs[i].b_neg, vecs[i].b_cnt);
      @(negedge clk);
    end

    // Async reset mid-pulse: raise the input, catch the pulse, then reset between edges.
    signal_in = 1'b1;
    @(posedge clk);
    #1;
    check("mid_pulse_a_pos", 100, 32'(pos_a), 32'd1);
    check("mid_pulse_a_cnt", 100, 32'(cnt_a), 32'd6);
    #2;
    rst = 1'b1;
    #1;
    check_all(101, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    check_all(102, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'd0);

    // Release with the input already high: reported as a rising edge at the first
    // sampling edge; the synchronized instance reports it two edges later.
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all(103, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 2'd0);
    @(posedge clk);
    #1;
    check_all(104, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 2'd0);
    @(posedge clk);
    #1;
    check_all(105, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 2'd1);
    @(posedge clk);
    #1;
    check_all(106, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 2'd1);

    // Short glitch low that does not straddle a rising edge stays invisible.
    @(negedge clk);
    signal_in = 1'b0;
    #2;
    signal_in = 1'b1;
    @(posedge clk);
    #1;
    check_all(107, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 2'd1);
    @(posedge clk);
    #1;
    check_all(108, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
